// File: rtl/key_event_sched.sv
// Key event scheduler: captures per-key debounced transitions, arbitrates
// them round-robin into a small event FIFO, and tracks lost events.
module key_event_sched #(
    parameter int NUM_KEYS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_event,
    input  logic [3:0] key_status,
    input  logic       ev_ready,
    input  logic       clr_ovf,
    output logic       ev_valid,
    output logic [1:0] ev_key,
    output logic       ev_press,
    output logic [2:0] fifo_count,
    output logic       overflow
);

    logic [3:0] pend;
    logic [3:0] ptype;
    logic [1:0] rr_ptr;
    logic [2:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    logic       full;
    logic       gnt_vld;
    logic [1:0] gnt_key;
    logic [1:0] idx;
    logic [3:0] gnt_oh;
    logic       pop;
    logic       ovf_set;

    assign full = (fifo_count == 3'(FIFO_DEPTH));

    // Walk the search order backwards so the earliest candidate wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_key = 2'd0;
        idx     = 2'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (pend[idx] && !full) begin
                gnt_vld = 1'b1;
                gnt_key = idx;
            end
        end
    end

    assign gnt_oh  = gnt_vld ? (4'b0001 << gnt_key) : 4'b0000;
    assign pop     = ev_valid & ev_ready;
    assign ovf_set = |(key_event & pend & ~gnt_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 4'b0000;
            ptype      <= 4'b0000;
            rr_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            // A fresh event on the granted key re-arms it with the new type.
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (gnt_oh[i]) pend[i] <= 1'b0;
                if (key_event[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= ~key_status[i];
                end
            end
            if (gnt_vld) begin
                mem[wr_ptr] <= {gnt_key, ptype[gnt_key]};
                wr_ptr      <= wr_ptr + 2'd1;
                rr_ptr      <= gnt_key + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({gnt_vld, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign ev_valid = (fifo_count != 3'd0);
    assign ev_key   = ev_valid ? mem[rd_ptr][2:1] : 2'd0;
    assign ev_press = ev_valid ? mem[rd_ptr][0] : 1'b0;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: reset, latency, contention,
// backpressure, re-event overflow, same-cycle re-arm and mid-stream reset.
module tb_key_event_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_event = 4'b0000;
    logic [3:0] key_status = 4'b1111;
    logic       ev_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_key;
    logic       ev_press;
    logic [2:0] fifo_count;
    logic       overflow;

    int vectors = 0;
    int errors  = 0;

    key_event_sched #(.NUM_KEYS(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_event  (key_event),
        .key_status (key_status),
        .ev_ready   (ev_ready),
        .clr_ovf    (clr_ovf),
        .ev_valid   (ev_valid),
        .ev_key     (ev_key),
        .ev_press   (ev_press),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 8'(ev_valid), 8'd0);
        check({tag, "_key"}, 8'(ev_key), 8'd0);
        check({tag, "_press"}, 8'(ev_press), 8'd0);
        check({tag, "_count"}, 8'(fifo_count), 8'd0);
        check({tag, "_ovf"}, 8'(overflow), 8'd0);
    endtask

    task automatic pop_check(input string tag, input logic [1:0] k,
                             input logic p);
        check({tag, "_valid"}, 8'(ev_valid), 8'd1);
        check({tag, "_key"}, 8'(ev_key), 8'(k));
        check({tag, "_press"}, 8'(ev_press), 8'(p));
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
    endtask

    initial begin
        // Reset overrides activity on the inputs
        rst = 1'b1; key_event = 4'b1111; key_status = 4'b0000;
        ev_ready = 1'b1;
        step();
        step();
        rst = 1'b0; key_event = 4'b0000; ev_ready = 1'b0;
        check_idle("reset");
        step();
        check_idle("reset_hold");

        // Single event, two-edge latency
        key_event = 4'b0100; key_status = 4'b1011;
        step();
        key_event = 4'b0000;
        check("lat_n1_valid", 8'(ev_valid), 8'd0);
        step();
        check("lat_n2_count", 8'(fifo_count), 8'd1);
        pop_check("single", 2'd2, 1'b1);
        check_idle("single_drained");
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check("pop_empty_count", 8'(fifo_count), 8'd0);

        // Contention from rr_ptr=0 after reset
        rst = 1'b1; step(); rst = 1'b0;
        key_event = 4'b1111; key_status = 4'b0000;
        step();
        key_event = 4'b0000;
        step(); check("cont_c1", 8'(fifo_count), 8'd1);
        step(); check("cont_c2", 8'(fifo_count), 8'd2);
        step(); check("cont_c3", 8'(fifo_count), 8'd3);
        step(); check("cont_c4", 8'(fifo_count), 8'd4);
        step(); check("cont_c4b", 8'(fifo_count), 8'd4);
        pop_check("cont0", 2'd0, 1'b1);
        pop_check("cont1", 2'd1, 1'b1);
        pop_check("cont2", 2'd2, 1'b1);
        pop_check("cont3", 2'd3, 1'b1);
        check("cont_empty", 8'(fifo_count), 8'd0);

        // Full FIFO with key 1 release pending; hold backpressure
        key_event = 4'b1111; key_status = 4'b0000;
        step();
        key_event = 4'b0000;
        step();
        step();
        key_event = 4'b0010; key_status = 4'b0010;
        step();
        key_event = 4'b0000;
        step();
        check("full_count", 8'(fifo_count), 8'd4);
        repeat (10) step();
        check("bp_count", 8'(fifo_count), 8'd4);
        check("bp_key", 8'(ev_key), 8'd0);
        check("bp_ovf", 8'(overflow), 8'd0);
        pop_check("bp0", 2'd0, 1'b1);
        check("bp_pop_count", 8'(fifo_count), 8'd3);
        step();
        check("bp_refill", 8'(fifo_count), 8'd4);
        pop_check("bp1", 2'd1, 1'b1);
        pop_check("bp2", 2'd2, 1'b1);
        pop_check("bp3", 2'd3, 1'b1);
        pop_check("bp4", 2'd1, 1'b0);
        check("bp_empty", 8'(fifo_count), 8'd0);

        // Key 3 re-event while blocked by a full FIFO (rr_ptr=2)
        key_event = 4'b0111; key_status = 4'b0000;
        step();
        key_event = 4'b0000;
        step();
        step();
        key_event = 4'b0001;
        step();
        key_event = 4'b0000;
        step();
        check("re_full", 8'(fifo_count), 8'd4);
        key_event = 4'b1000; key_status = 4'b0000;
        step();
        check("re_first_ovf", 8'(overflow), 8'd0);
        key_status = 4'b1000;
        step();
        key_event = 4'b0000;
        check("re_ovf_set", 8'(overflow), 8'd1);
        check("re_count", 8'(fifo_count), 8'd4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("re_ovf_clr", 8'(overflow), 8'd0);
        pop_check("re0", 2'd2, 1'b1);
        pop_check("re1", 2'd0, 1'b1);
        pop_check("re2", 2'd1, 1'b1);
        pop_check("re3", 2'd0, 1'b1);
        pop_check("re4", 2'd3, 1'b0);
        check("re_empty", 8'(fifo_count), 8'd0);

        // Grant and new event on key 0 in the same cycle (rr_ptr=0)
        key_event = 4'b0001; key_status = 4'b0000;
        step();
        key_status = 4'b0001;
        step();
        key_event = 4'b0000;
        check("same_c1", 8'(fifo_count), 8'd1);
        check("same_ovf", 8'(overflow), 8'd0);
        step();
        check("same_c2", 8'(fifo_count), 8'd2);
        pop_check("same0", 2'd0, 1'b1);
        pop_check("same1", 2'd0, 1'b0);
        check("same_empty", 8'(fifo_count), 8'd0);

        // Reset with three queued entries and key 0 still pending (rr_ptr=1)
        key_event = 4'b1111; key_status = 4'b0000;
        step();
        key_event = 4'b0000;
        step(); step(); step();
        check("mid_count", 8'(fifo_count), 8'd3);
        rst = 1'b1; ev_ready = 1'b1; key_event = 4'b1111;
        step();
        rst = 1'b0; ev_ready = 1'b0; key_event = 4'b0000;
        check_idle("mid_rst");
        step();
        step();
        check_idle("mid_rst_hold");
        key_event = 4'b1010; key_status = 4'b0000;
        step();
        key_event = 4'b0000;
        step();
        step();
        check("post_count", 8'(fifo_count), 8'd2);
        pop_check("post0", 2'd1, 1'b1);
        pop_check("post1", 2'd3, 1'b1);
        check_idle("post_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/key_event_sched.md
KEY_EVENT_SCHED -- requirements
Module: key_event_sched

Interface
REQ-001 Parameter NUM_KEYS, 4, number of debounced key channels; fixed at 4 for this release.
REQ-002 Parameter FIFO_DEPTH, 4, event queue depth in entries.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_event  input  4  per-key one-cycle pulse from a key_filter instance on each debounced state change.
REQ-006 key_status  input  4  per-key debounced level; 0 = pressed, 1 = released.
REQ-007 ev_ready  input  1  consumer accepts the head event this cycle.
REQ-008 clr_ovf  input  1  one-cycle pulse clearing the overflow flag.
REQ-009 ev_valid  output  1  head event present.
REQ-010 ev_key  output  2  key index of head event.
REQ-011 ev_press  output  1  head event type; 1 = press, 0 = release.
REQ-012 fifo_count  output  3  number of queued events, 0..4.
REQ-013 overflow  output  1  sticky lost-event flag.

Function
REQ-014 Capture: on a cycle with key_event[i]=1, the block SHALL set pend[i] and store ptype[i] = ~key_status[i], sampled in that same cycle.
REQ-015 Re-event: key_event[i] while pend[i] is already set and not granted that cycle SHALL overwrite ptype[i] and set overflow.
REQ-016 Arbitration: each cycle where any pend bit is set and fifo_count < FIFO_DEPTH at cycle start, exactly one key SHALL be granted, chosen round-robin starting from rr_ptr, the search order being rr_ptr, rr_ptr+1, ... mod 4.
REQ-017 After a grant to key g, rr_ptr SHALL become (g+1) mod 4; rr_ptr SHALL be unchanged on cycles without a grant.
REQ-018 Grant action: the block SHALL write {g, ptype[g]} into the FIFO tail and clear pend[g] at the same clock edge.
REQ-019 Grant plus new event on the same key in the same cycle: the FIFO SHALL receive the old ptype; pend[g] SHALL remain set with the new type; set wins over clear; overflow SHALL NOT be set.
REQ-020 Full: with fifo_count = FIFO_DEPTH at cycle start, no grant SHALL occur, even if a pop occurs in the same cycle; pending bits SHALL be held.
REQ-021 Output: ev_valid = (fifo_count != 0); ev_key and ev_press SHALL reflect the head entry, and both SHALL be 0 when the FIFO is empty.
REQ-022 Pop: ev_valid & ev_ready SHALL remove the head at the clock edge; ev_ready while empty SHALL have no effect.
REQ-023 Simultaneous push and pop: fifo_count SHALL be unchanged and order SHALL be preserved.
REQ-024 Latency: with an empty FIFO and no contention, key_event at edge n SHALL produce ev_valid=1 after edge n+2; pend is set at n+1 and the FIFO is written at n+2.
REQ-025 Ordering: events SHALL leave in FIFO write order; head data SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-026 overflow SHALL be cleared only by clr_ovf or rst; if clr_ovf and a new set condition coincide, set SHALL win.
REQ-027 FIFO read and write pointers SHALL wrap mod FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-028 With rst=1 at an edge, the block SHALL clear pend to 0000, ptype to 0000, rr_ptr to 0, FIFO pointers and fifo_count to 0, and overflow to 0.
REQ-029 During and after reset: ev_valid=0, ev_key=0, ev_press=0, fifo_count=0, overflow=0.
REQ-030 Reset SHALL override all inputs in that cycle, including key_event and ev_ready.
REQ-031 Reset mid-operation SHALL discard all queued and pending events, with no partial pop.

Verification
REQ-032 Single event: after reset, pulse key_event=0100 with key_status=1011 -> two edges later ev_valid=1, ev_key=2, ev_press=1; ev_ready=1 -> fifo_count=0.
REQ-033 Contention: key_event=1111 with all keys pressed, ev_ready=0 -> FIFO order keys 0,1,2,3; fifo_count=4; rr_ptr=0.
REQ-034 Full and backpressure: with FIFO full and pend[1] set, hold ev_ready=0 for 10 cycles -> fifo_count=4 and pend held; one pop -> key 1 written on the next cycle.
REQ-035 Re-event: key 3 press is pending and blocked by a full FIFO, then key 3 release arrives -> overflow=1; the entry later emitted is key 3 with ev_press=0; clr_ovf -> overflow=0.
REQ-036 Same-cycle grant and new event on key 0: queued entry has the press type, pend[0] stays set, next entry is key 0 release, overflow=0.
REQ-037 Reset mid-stream: fifo_count=3 plus pending bits, assert rst for 1 cycle -> all outputs 0 on the following cycle; new events process normally starting from rr_ptr=0.
